// File: rtl/clk_div_bank_pkg.sv
// Shared types for the clock/pulse divider bank: channel modes, the
// per-channel configuration record and reset defaults.
package clk_div_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_PULSE  = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

  // Fields are sized for the widest supported bank (CNT_W <= 256, BURST_W <= 16).
  localparam int CFG_SHIFT_W = 8;
  localparam int CFG_BURST_W = 16;

  typedef struct packed {
    mode_t                  mode;
    logic [CFG_SHIFT_W-1:0] shift;
    logic [CFG_BURST_W-1:0] burst;
  } ch_cfg_t;

  function automatic logic [CFG_SHIFT_W-1:0] default_shift(input int ch);
    return CFG_SHIFT_W'(ch);
  endfunction

  function automatic ch_cfg_t default_cfg(input int ch);
    ch_cfg_t cfg_v;
    cfg_v.mode  = MODE_SQUARE;
    cfg_v.shift = default_shift(ch);
    cfg_v.burst = {CFG_BURST_W{1'b0}};
    return cfg_v;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: pending/active config, period-boundary commit,
// burst period counter and the registered output.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int CH_IDX = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wr,
  input  ch_cfg_t          wr_cfg,
  output logic             ch_out,
  output logic             ch_pend,
  output logic             ch_done
);

  localparam logic [CNT_W-1:0]       CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CFG_BURST_W-1:0] BCNT_ONE  = {{(CFG_BURST_W-1){1'b0}}, 1'b1};
  localparam logic [CFG_BURST_W-1:0] BCNT_ZERO = {CFG_BURST_W{1'b0}};

  ch_cfg_t                act_r, pend_cfg_r, act_nxt_s;
  logic                   pend_r, done_r, out_r;
  logic                   done_nxt_s, out_nxt_s, commit_s, act_bnd_s;
  logic [CFG_BURST_W-1:0] bcnt_r, bcnt_nxt_s;
  logic [CFG_SHIFT_W-1:0] m_s;
  logic [CNT_W-1:0]       cnt_nxt_s, m_mask_s, act_mask_s, nxt_mask_s, nxt_top_s;

  // Ones in bits [s:0]; s is already clamped to CNT_W-1 by the top level.
  function automatic logic [CNT_W-1:0] low_mask(input logic [CFG_SHIFT_W-1:0] s);
    logic [CNT_W-1:0] ones_v;
    ones_v = {CNT_W{1'b1}};
    return ones_v >> (CNT_W - 1 - int'(s));
  endfunction

  // Commit detect, burst bookkeeping and next output value (computed from cnt+1).
  always_comb begin
    if (act_r.mode == MODE_OFF || pend_cfg_r.shift > act_r.shift) begin
      m_s = pend_cfg_r.shift;
    end else begin
      m_s = act_r.shift;
    end
    m_mask_s   = low_mask(m_s);
    act_mask_s = low_mask(act_r.shift);
    commit_s   = pend_r && ((cnt & m_mask_s) == m_mask_s);
    act_bnd_s  = (cnt & act_mask_s) == act_mask_s;
    cnt_nxt_s  = cnt + CNT_ONE;

    act_nxt_s  = act_r;
    bcnt_nxt_s = bcnt_r;
    done_nxt_s = done_r;
    if (commit_s) begin
      act_nxt_s  = pend_cfg_r;
      bcnt_nxt_s = pend_cfg_r.burst;
      done_nxt_s = (pend_cfg_r.mode == MODE_BURST) && (pend_cfg_r.burst == BCNT_ZERO);
    end else if (act_r.mode == MODE_BURST && bcnt_r != BCNT_ZERO && act_bnd_s) begin
      bcnt_nxt_s = bcnt_r - BCNT_ONE;
      done_nxt_s = done_r | (bcnt_nxt_s == BCNT_ZERO);
    end else begin
      done_nxt_s = done_r;
    end

    nxt_mask_s = low_mask(act_nxt_s.shift);
    nxt_top_s  = nxt_mask_s & ~(nxt_mask_s >> 1);
    case (act_nxt_s.mode)
      MODE_SQUARE: out_nxt_s = |(cnt_nxt_s & nxt_top_s);
      MODE_PULSE:  out_nxt_s = (cnt_nxt_s & nxt_mask_s) == nxt_mask_s;
      MODE_BURST:  out_nxt_s = (bcnt_nxt_s != BCNT_ZERO) && |(cnt_nxt_s & nxt_top_s);
      default:     out_nxt_s = 1'b0;
    endcase
  end

  // Channel state; a write in the commit cycle lands in pending after the old value commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_r      <= default_cfg(CH_IDX);
      pend_cfg_r <= default_cfg(CH_IDX);
      pend_r     <= 1'b0;
      done_r     <= 1'b0;
      bcnt_r     <= BCNT_ZERO;
      out_r      <= 1'b0;
    end else begin
      act_r  <= act_nxt_s;
      bcnt_r <= bcnt_nxt_s;
      done_r <= done_nxt_s;
      out_r  <= out_nxt_s;
      if (wr) begin
        pend_cfg_r <= wr_cfg;
        pend_r     <= 1'b1;
      end else if (commit_s) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign ch_out  = out_r;
  assign ch_pend = pend_r;
  assign ch_done = done_r;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH divided clock/pulse outputs sharing one free-running
// counter; per-channel config is committed only on period boundaries.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                cfg_mode,
  input  logic [$clog2(CNT_W)-1:0]  cfg_shift,
  input  logic [BURST_W-1:0]        cfg_burst,
  output logic [NUM_CH-1:0]         ch_out,
  output logic [NUM_CH-1:0]         ch_pend,
  output logic [NUM_CH-1:0]         ch_done
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CNT_W-1:0] cnt_r;
  ch_cfg_t          wr_cfg_s;

  // Shared free-running counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Write decode with shift clamping.
  always_comb begin
    wr_cfg_s.mode  = mode_t'(cfg_mode);
    wr_cfg_s.burst = CFG_BURST_W'(cfg_burst);
    if (int'(cfg_shift) >= CNT_W) begin
      wr_cfg_s.shift = CFG_SHIFT_W'(CNT_W - 1);
    end else begin
      wr_cfg_s.shift = CFG_SHIFT_W'(cfg_shift);
    end
  end

  // Channel indices >= NUM_CH match no instance, so such writes fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W (CNT_W),
      .CH_IDX(i)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .cnt    (cnt_r),
      .wr     (cfg_wr && (cfg_ch == CH_W'(i))),
      .wr_cfg (wr_cfg_s),
      .ch_out (ch_out[i]),
      .ch_pend(ch_pend[i]),
      .ch_done(ch_done[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: integer-arithmetic reference model checked
// every cycle, plus hand-computed expectations at fixed counter values.
module tb_clk_div_bank;

  localparam int NUM_CH  = 7;
  localparam int CNT_W   = 12;
  localparam int BURST_W = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_wr = 1'b0;
  logic [2:0]         cfg_ch = 3'd0;
  logic [1:0]         cfg_mode = 2'd0;
  logic [3:0]         cfg_shift = 4'd0;
  logic [BURST_W-1:0] cfg_burst = 8'd0;
  logic [NUM_CH-1:0]  ch_out, ch_pend, ch_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: state describes the cycle currently on the outputs.
  bit started = 1'b0;
  int m_cyc = 0;
  int m_mode [NUM_CH];
  int m_shift[NUM_CH];
  int m_left [NUM_CH];
  int m_done [NUM_CH];
  int p_valid[NUM_CH];
  int p_mode [NUM_CH];
  int p_shift[NUM_CH];
  int p_burst[NUM_CH];

  clk_div_bank #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .BURST_W(BURST_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_shift(cfg_shift),
    .cfg_burst(cfg_burst),
    .ch_out   (ch_out),
    .ch_pend  (ch_pend),
    .ch_done  (ch_done)
  );

  always #5 clk = ~clk;

  function automatic bit is_bnd(input int c, input int s);
    return (c % (1 << (s + 1))) == (1 << (s + 1)) - 1;
  endfunction

  function automatic bit bit_of(input int c, input int s);
    return ((c >> s) & 1) == 1;
  endfunction

  function automatic bit exp_out(input int i);
    case (m_mode[i])
      1:       return bit_of(m_cyc, m_shift[i]);
      2:       return is_bnd(m_cyc, m_shift[i]);
      3:       return (m_left[i] > 0) && bit_of(m_cyc, m_shift[i]);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model update at each active edge from the inputs held during the ending cycle.
  initial begin
    int mm;
    forever begin
      @(posedge clk);
      if (reset) begin
        started = 1'b1;
        m_cyc   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
          m_mode[i] = 1; m_shift[i] = i; m_left[i] = 0; m_done[i] = 0;
          p_valid[i] = 0; p_mode[i] = 0; p_shift[i] = 0; p_burst[i] = 0;
        end
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (m_mode[i] == 0) mm = p_shift[i];
          else mm = (p_shift[i] > m_shift[i]) ? p_shift[i] : m_shift[i];
          if (p_valid[i] != 0 && is_bnd(m_cyc, mm)) begin
            m_mode[i]  = p_mode[i];
            m_shift[i] = p_shift[i];
            m_left[i]  = p_burst[i];
            m_done[i]  = (p_mode[i] == 3 && p_burst[i] == 0) ? 1 : 0;
            p_valid[i] = 0;
          end else if (m_mode[i] == 3 && m_left[i] > 0 && is_bnd(m_cyc, m_shift[i])) begin
            m_left[i]--;
            if (m_left[i] == 0) m_done[i] = 1;
          end
        end
        if (cfg_wr && int'(cfg_ch) < NUM_CH) begin
          p_valid[cfg_ch] = 1;
          p_mode[cfg_ch]  = int'(cfg_mode);
          p_shift[cfg_ch] = (int'(cfg_shift) >= CNT_W) ? CNT_W - 1 : int'(cfg_shift);
          p_burst[cfg_ch] = int'(cfg_burst);
        end
        m_cyc = (m_cyc + 1) % (1 << CNT_W);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    logic [NUM_CH-1:0] eo, ep, ed;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < NUM_CH; i++) begin
          eo[i] = exp_out(i);
          ep[i] = (p_valid[i] != 0);
          ed[i] = (m_done[i] != 0);
        end
        check($sformatf("ch_out@%0d", m_cyc),  32'(ch_out),  32'(eo));
        check($sformatf("ch_pend@%0d", m_cyc), 32'(ch_pend), 32'(ep));
        check($sformatf("ch_done@%0d", m_cyc), 32'(ch_done), 32'(ed));
      end
    end
  end

  task automatic wait_cnt(input int v);
    int n;
    n = 0;
    while (m_cyc != v && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (m_cyc != v) begin
      n_checks++;
      $display("FAIL wait_cnt: reached %0d, wanted %0d", m_cyc, v);
    end
  endtask

  task automatic do_write(input int ch, input int mode, input int shift, input int burst);
    cfg_ch    = 3'(ch);
    cfg_mode  = 2'(mode);
    cfg_shift = 4'(shift);
    cfg_burst = 8'(burst);
    cfg_wr    = 1'b1;
    @(negedge clk);
    cfg_wr    = 1'b0;
  endtask

  initial begin
    int pat[4];
    int highs;
    pat = '{0, 1, 0, 1};

    // Reset, then free-running defaults.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("sq0_pattern", 32'(ch_out[0]), 32'(pat[k]));
      @(negedge clk);
    end
    wait_cnt(63);  check("ch6_lo63", 32'(ch_out[6]), 32'd0);
    wait_cnt(64);  check("ch6_hi64", 32'(ch_out[6]), 32'd1);
    wait_cnt(127); check("ch6_hi127", 32'(ch_out[6]), 32'd1);
    wait_cnt(128); check("ch6_lo128", 32'(ch_out[6]), 32'd0);
    wait_cnt(511);
    check("idle_pend", 32'(ch_pend), 32'd0);
    check("idle_done", 32'(ch_done), 32'd0);

    // ch2 SQUARE shift 4 written at cnt low bits 5, commits after cnt[4:0]=31.
    wait_cnt(517); do_write(2, 1, 4, 0);
    check("ch2_pend_set", 32'(ch_pend[2]), 32'd1);
    wait_cnt(543); check("ch2_pend_543", 32'(ch_pend[2]), 32'd1);
    wait_cnt(544);
    check("ch2_pend_clr", 32'(ch_pend[2]), 32'd0);
    check("ch2_out_544", 32'(ch_out[2]), 32'd0);
    wait_cnt(559); check("ch2_out_559", 32'(ch_out[2]), 32'd0);
    wait_cnt(560); check("ch2_out_560", 32'(ch_out[2]), 32'd1);

    // ch1 PULSE shift 3.
    wait_cnt(600); do_write(1, 2, 3, 0);
    wait_cnt(607); check("ch1_pend_607", 32'(ch_pend[1]), 32'd1);
    wait_cnt(608); check("ch1_pend_608", 32'(ch_pend[1]), 32'd0);
    wait_cnt(622); check("ch1_pulse_622", 32'(ch_out[1]), 32'd0);
    wait_cnt(623); check("ch1_pulse_623", 32'(ch_out[1]), 32'd1);
    wait_cnt(624); check("ch1_pulse_624", 32'(ch_out[1]), 32'd0);
    wait_cnt(639); check("ch1_pulse_639", 32'(ch_out[1]), 32'd1);

    // ch0 BURST shift 1, 3 periods: commit at 703, high cycles 706,707,710,711,714,715.
    wait_cnt(700); do_write(0, 3, 1, 3);
    wait_cnt(704);
    highs = 0;
    for (int k = 0; k < 28; k++) begin
      if (m_cyc == 715) check("ch0_done_715", 32'(ch_done[0]), 32'd0);
      if (m_cyc == 716) check("ch0_done_716", 32'(ch_done[0]), 32'd1);
      highs += int'(ch_out[0]);
      @(negedge clk);
    end
    check("ch0_burst_highs", 32'(highs), 32'd6);
    wait_cnt(740); do_write(0, 1, 0, 0);
    wait_cnt(743); check("ch0_done_743", 32'(ch_done[0]), 32'd1);
    wait_cnt(744);
    check("ch0_done_clr", 32'(ch_done[0]), 32'd0);
    check("ch0_sq_744", 32'(ch_out[0]), 32'd0);
    wait_cnt(745); check("ch0_sq_745", 32'(ch_out[0]), 32'd1);

    // ch3: shift 5 then shift 2 before commit; only shift 2 commits (at 815).
    wait_cnt(800); do_write(3, 1, 5, 0);
    wait_cnt(803); do_write(3, 1, 2, 0);
    wait_cnt(815); check("ch3_pend_815", 32'(ch_pend[3]), 32'd1);
    wait_cnt(816); check("ch3_pend_816", 32'(ch_pend[3]), 32'd0);
    wait_cnt(820); check("ch3_out_820", 32'(ch_out[3]), 32'd1);
    wait_cnt(824); check("ch3_out_824", 32'(ch_out[3]), 32'd0);

    // ch0 BURST shift 2 x5 from 856, pending write on ch5, then reset mid-burst.
    wait_cnt(850); do_write(0, 3, 2, 5);
    wait_cnt(868); do_write(5, 2, 1, 0);
    wait_cnt(870); check("ch0_burst_870", 32'(ch_out[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_out", 32'(ch_out), 32'd0);
    check("rst_pend", 32'(ch_pend), 32'd0);
    check("rst_done", 32'(ch_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_out0", 32'(ch_out), 32'd0);
    wait_cnt(1); check("post_rst_out1", 32'(ch_out), 32'h01);
    wait_cnt(3); check("post_rst_out3", 32'(ch_out), 32'h03);
    wait_cnt(4);
    check("post_rst_out4", 32'(ch_out), 32'h04);
    check("post_rst_pend", 32'(ch_pend), 32'd0);

    // Out-of-range channel ignored; out-of-range shift clamps to CNT_W-1.
    wait_cnt(100); do_write(7, 1, 0, 0);
    check("bad_ch_pend", 32'(ch_pend), 32'd0);
    wait_cnt(120); do_write(4, 1, CNT_W, 0);
    wait_cnt(4095); check("ch4_pend_4095", 32'(ch_pend[4]), 32'd1);
    wait_cnt(0);    check("ch4_pend_0", 32'(ch_pend[4]), 32'd0);
    wait_cnt(16);   check("ch4_out_16", 32'(ch_out[4]), 32'd0);
    wait_cnt(2047); check("ch4_out_2047", 32'(ch_out[4]), 32'd0);
    wait_cnt(2048); check("ch4_out_2048", 32'(ch_out[4]), 32'd1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised, fully synchronous bank of NUM_CH clock/pulse generators, all driven by one shared free-running counter. No ripple or derived clocks.
- Each channel is runtime-configurable: divide ratio 2^(shift+1) and one of four modes (off, square, pulse, burst).
- Reconfiguration is glitch-free: a new config is committed only on a period boundary.
- Sits between the system clock and the external signal gating/AND logic. Reset defaults give channel i = clk/2^(i+1).

Parameters:
- NUM_CH, 8: number of output channels; must be <= CNT_W.
- CNT_W, 16: shared counter width; shift range is 0..CNT_W-1.
- BURST_W, 8: width of the burst period count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cfg_wr  in  1  one-cycle config write strobe
- cfg_ch  in  $clog2(NUM_CH)  target channel; values >= NUM_CH are ignored
- cfg_mode  in  2  0=OFF, 1=SQUARE, 2=PULSE, 3=BURST
- cfg_shift  in  $clog2(CNT_W)  divide = 2^(cfg_shift+1); values >= CNT_W clamp to CNT_W-1
- cfg_burst  in  BURST_W  number of full periods in BURST mode
- ch_out  out  NUM_CH  registered channel outputs
- ch_pend  out  NUM_CH  config written but not yet committed
- ch_done  out  NUM_CH  burst complete (sticky)

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset:
  - cnt=0, ch_out=0, ch_pend=0, ch_done=0.
  - Channel i active config = SQUARE, shift=i, burst count 0.
  - Reset mid-operation discards all pending and active state; behaviour resumes as from power-up.
- cnt: increments by 1 every cycle and wraps from 2^CNT_W-1 to 0. The wrap has no special behaviour.
- Notation: with active shift s, c(t) is the cnt value in cycle t. A boundary cycle is one where c[s:0] is all ones.
- ch_out[i] is a flop. Its value in cycle t is a function of c(t) and the active config (the flop is loaded one cycle early from cnt+1). There is no combinational path from cnt to the pin.
  - OFF: 0.
  - SQUARE: c[s].
  - PULSE: 1 only in boundary cycles (one clk wide, once per period).
  - BURST: c[s] while the burst count > 0, else 0.
- Config write:
  - cfg_wr loads the channel's pending register and sets ch_pend[i] on the next cycle.
  - A second write before commit overwrites the pending config; last write wins.
- Commit point:
  - Let m = max(s_active, s_pending). Commit happens at the end of the cycle where c[m:0] is all ones. If the active mode is OFF, m = s_pending.
  - The new config drives ch_out from the following cycle. ch_pend clears in that same cycle.
  - Consequence: no runt high or low phase is ever emitted. The first new period is always full.
  - Worst-case commit latency is 2^CNT_W cycles.
- Write and commit in the same cycle for the same channel: the commit uses the old pending value. The new write becomes pending and ch_pend stays 1.
- BURST:
  - At commit the burst count loads cfg_burst and ch_done clears.
  - The count decrements at each boundary cycle while > 0.
  - The 1->0 transition sets ch_done on the next cycle; ch_out is then 0.
  - cfg_burst=0 gives output 0 and ch_done=1 in the cycle after commit.
- Commit of any non-BURST mode clears ch_done.
- Channels are fully independent. Simultaneous commits on several channels are permitted.

Decomposition:
- Package clk_div_bank_pkg:
  - mode enum (OFF/SQUARE/PULSE/BURST) and its 2-bit width
  - typedef ch_cfg_t {mode, shift, burst}
  - function for reset-default shift = channel index
- One natural sub-module, clk_div_chan: one channel holding pending/active config, commit detect, burst counter and output flop. It takes the shared cnt as input.
- Top level: counter, write decode, generate loop over clk_div_chan.

Test Plan:
- Reset, then 512 cycles, no writes -> ch_out[i] toggles every 2^i cycles. ch_out[0] pattern 0,1,0,1 from the first cycle after reset; ch_out[7] period 256. ch_pend=ch_done=0.
- Write ch2 SQUARE shift=4 at cnt=5 -> ch_pend[2]=1 until the cycle after cnt=31. From cnt=32, ch_out[2]=cnt[4] (period 32). No high or low phase shorter than 4 cycles at the switch.
- Write ch1 PULSE shift=3 -> after commit, ch_out[1] is high exactly 1 cycle per 16, at cnt[3:0]=15.
- Write ch0 BURST shift=1 burst=3 -> after commit exactly 3 full periods of 4 cycles. ch_out[0]=0 and ch_done[0]=1 from then on. A following SQUARE write clears ch_done[0] on commit.
- Two writes to ch3 before commit (shift 5 then shift 2), plus assert reset mid-burst on ch0 -> ch3 commits shift=2 only. Reset returns every output to 0 and channel i to SQUARE shift=i.
- cfg_ch=NUM_CH and cfg_shift=CNT_W -> the bad channel is ignored (no ch_pend change). The bad shift clamps to CNT_W-1.
